fighter_renderer: RTL and testbench
===================================

FIGHTER_RENDERER -- requirements
Module: fighter_renderer

Interface
REQ-001 SHALL have parameters: SPRITE_W, default 64, sprite width in pixels; SPRITE_H, default 96, sprite height in pixels; FLOOR_Y, default 400, first floor row; BG_RGB, default 24'h203060, background colour; FLOOR_RGB, default 24'h404040, floor colour; P1_RGB, default 24'hE02020, player-1 colour; P2_RGB, default 24'h2040E0, player-2 colour.
REQ-002 SHALL have ports, clock and reset first: clk in 1, pixel clock; reset in 1, synchronous active-low reset; x_coord in 10, active pixel column; y_coord in 10, active pixel row; display_en in 1, active-region flag; hsync_in in 1, active-low hsync; vsync_in in 1, active-low vsync.
REQ-003 SHALL have ports: p1_x in 10, p1_y in 10, p2_x in 10, p2_y in 10, sprite top-left positions; pos_valid in 1; pos_ready out 1; frame_start out 1.
REQ-004 SHALL have ports: vga_r out 8, vga_g out 8, vga_b out 8, vga_hs out 1, vga_vs out 1, vga_blank_n out 1; hit out 1, present only when FIGHTER_HITBOX_EN is defined.

Function
REQ-005 Clock is clk only; reset is synchronous and active-low.
REQ-006 Pipeline: exactly 2-cycle latency from x_coord/y_coord/display_en/hsync_in/vsync_in to vga_r/g/b/vga_blank_n/vga_hs/vga_vs; sync and blank delayed identically to colour.
REQ-007 Stage 1 registers per-sprite inside flags; stage 2 registers colour select.
REQ-008 Sprite n inside iff x >= pn_x, x < pn_x+SPRITE_W, y >= pn_y, y < pn_y+SPRITE_H; sums computed 11-bit, no wrap; sprites partly off-screen clip naturally.
REQ-009 Colour priority: P1 over P2 over floor (y >= FLOOR_Y) over background.
REQ-010 display_en low: RGB forced 0, vga_blank_n 0.
REQ-011 Position handshake: transfer when pos_valid and pos_ready both high at a clk edge; all four positions captured into a pending register, pending_full set.
REQ-012 pos_ready = ~pending_full; pos_valid while pos_ready low is ignored, and its data is not required to be held.
REQ-013 Frame boundary = vsync_in falling edge (registered previous value 1, current 0); frame_start pulses high exactly one cycle, in the cycle after the edge is sampled.
REQ-014 At frame boundary with pending_full: active positions load pending, pending_full clears; without it: active positions unchanged.
REQ-015 Active positions never change mid-frame; no tearing.
REQ-016 Accept and commit cannot coincide (mutually exclusive on pending_full); an accept in the cycle after commit is legal.

Reset
REQ-017 During reset: RGB 0, vga_blank_n 0, vga_hs 1, vga_vs 1, frame_start 0, pos_ready 1, pending_full 0, hit 0, pipeline flags 0.
REQ-018 Active positions reset to P1 (64,FLOOR_Y-SPRITE_H), P2 (512,FLOOR_Y-SPRITE_H); previous-vsync register resets to 1.
REQ-019 Reset mid-frame or mid-handshake: pending data discarded; no frame_start until the next real falling edge.

Configuration
REQ-020 Macro FIGHTER_HITBOX_EN defined: sticky overlap flag sets when both sprites are inside on any displayed pixel; at frame boundary hit <= flag for one full frame and flag clears.
REQ-021 Macro absent: no hit port, no overlap logic; all other behaviour identical.

Structure
REQ-022 Shared package fightpga_pkg SHALL hold the 24-bit rgb type, colour constants, and SPRITE_W/SPRITE_H/FLOOR_Y defaults.
REQ-023 One sub-module, sprite_hit_test, SHALL compute the REQ-008 inside test, instantiated twice.

Verification
REQ-024 Reset held 3 cycles -> all outputs at REQ-017 values; pos_ready 1.
REQ-025 P1 at (100,200), pixel stream (100,200) display_en 1 -> two cycles later RGB E0/20/20; (164,200) -> BG 20/30/60.
REQ-026 P1 and P2 both at (300,300), pixel (310,310) -> P1 colour; with macro, hit 1 for the next frame after the boundary, 0 the frame after if separated.
REQ-027 Accept (50,50) mid-frame -> pos_ready 0, rendering unchanged until vsync falling edge; frame_start one cycle pulse; new position rendered next frame; pos_ready 1.
REQ-028 P2 at (1000,0), pixel (639,0) -> background, no wrap hit; display_en 0 -> RGB 0, blank_n 0 with sync delayed exactly 2 cycles.
REQ-029 Reset asserted while pending_full -> after release, old pending never committed; defaults rendered.

Source files
------------

// File: rtl/fightpga_pkg.sv
`default_nettype none
// =============================================================================
// Module      : fightpga_pkg
// Description : Shared colour type, palette constants and sprite/floor geometry
// Revision    : 1.0 - initial release
// =============================================================================
package fightpga_pkg;

    typedef logic [23:0] rgb_t;

    localparam int   c_sprite_w  = 64;
    localparam int   c_sprite_h  = 96;
    localparam int   c_floor_y   = 400;

    localparam rgb_t c_bg_rgb    = 24'h203060;
    localparam rgb_t c_floor_rgb = 24'h404040;
    localparam rgb_t c_p1_rgb    = 24'hE02020;
    localparam rgb_t c_p2_rgb    = 24'h2040E0;

    localparam logic [9:0] c_p1_home_x = 10'd64;
    localparam logic [9:0] c_p2_home_x = 10'd512;

endpackage
`default_nettype wire

// File: rtl/sprite_hit_test.sv
`default_nettype none
// =============================================================================
// Module      : sprite_hit_test
// Description : Combinational test of whether a pixel lies inside one sprite box
// Revision    : 1.0 - initial release
// =============================================================================
module sprite_hit_test
    import fightpga_pkg::*;
#(
    parameter int SPRITE_W = c_sprite_w,
    parameter int SPRITE_H = c_sprite_h
) (
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    input  logic [9:0] pos_x_i,
    input  logic [9:0] pos_y_i,
    output logic       inside_o
);

    // Right/bottom edges are 11 bits wide so sprites hanging off-screen never wrap
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;

    assign w_x_end  = {1'b0, pos_x_i} + 11'(SPRITE_W);
    assign w_y_end  = {1'b0, pos_y_i} + 11'(SPRITE_H);

    assign inside_o = (x_i >= pos_x_i) && ({1'b0, x_i} < w_x_end) &&
                      (y_i >= pos_y_i) && ({1'b0, y_i} < w_y_end);

endmodule
`default_nettype wire

// File: rtl/fighter_renderer.sv
`default_nettype none
// =============================================================================
// Module      : fighter_renderer
// Description : Two-stage sprite/floor/background renderer with frame-synchronous
//               position updates. Define FIGHTER_HITBOX_EN to add the hit output.
// Revision    : 1.0 - initial release
// =============================================================================
module fighter_renderer
    import fightpga_pkg::*;
#(
    parameter int   SPRITE_W  = c_sprite_w,
    parameter int   SPRITE_H  = c_sprite_h,
    parameter int   FLOOR_Y   = c_floor_y,
    parameter rgb_t BG_RGB    = c_bg_rgb,
    parameter rgb_t FLOOR_RGB = c_floor_rgb,
    parameter rgb_t P1_RGB    = c_p1_rgb,
    parameter rgb_t P2_RGB    = c_p2_rgb
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x_coord,
    input  logic [9:0] y_coord,
    input  logic       display_en,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [9:0] p1_x,
    input  logic [9:0] p1_y,
    input  logic [9:0] p2_x,
    input  logic [9:0] p2_y,
    input  logic       pos_valid,
    output logic       pos_ready,
    output logic       frame_start,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n
`ifdef FIGHTER_HITBOX_EN
    ,output logic      hit
`endif
);

    localparam logic [9:0]  c_home_y = 10'(FLOOR_Y - SPRITE_H);
    localparam logic [10:0] c_floor  = 11'(FLOOR_Y);

    logic [9:0] p1_x_q, p1_y_q, p2_x_q, p2_y_q;
    logic [9:0] pend_p1_x_q, pend_p1_y_q, pend_p2_x_q, pend_p2_y_q;
    logic       pending_full_q;
    logic       vs_prev_q;
    logic       frame_start_q;

    logic       in1_q, in2_q, floor_q, de1_q, hs1_q, vs1_q;
    rgb_t       rgb_q, rgb_d;
    logic       blank_n_q, hs2_q, vs2_q;

    logic       w_in1, w_in2, w_edge, w_accept, w_commit;

    sprite_hit_test #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_hit_p1 (
        .x_i(x_coord), .y_i(y_coord), .pos_x_i(p1_x_q), .pos_y_i(p1_y_q), .inside_o(w_in1)
    );

    sprite_hit_test #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_hit_p2 (
        .x_i(x_coord), .y_i(y_coord), .pos_x_i(p2_x_q), .pos_y_i(p2_y_q), .inside_o(w_in2)
    );

    // Commit only happens with pending_full set and accept only with it clear
    assign w_edge   = vs_prev_q & ~vsync_in;
    assign w_accept = pos_valid & ~pending_full_q;
    assign w_commit = w_edge & pending_full_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            p1_x_q         <= c_p1_home_x;
            p1_y_q         <= c_home_y;
            p2_x_q         <= c_p2_home_x;
            p2_y_q         <= c_home_y;
            pend_p1_x_q    <= '0;
            pend_p1_y_q    <= '0;
            pend_p2_x_q    <= '0;
            pend_p2_y_q    <= '0;
            pending_full_q <= 1'b0;
            vs_prev_q      <= 1'b1;
            frame_start_q  <= 1'b0;
        end else begin
            vs_prev_q     <= vsync_in;
            frame_start_q <= w_edge;
            if (w_commit) begin
                p1_x_q         <= pend_p1_x_q;
                p1_y_q         <= pend_p1_y_q;
                p2_x_q         <= pend_p2_x_q;
                p2_y_q         <= pend_p2_y_q;
                pending_full_q <= 1'b0;
            end else if (w_accept) begin
                pend_p1_x_q    <= p1_x;
                pend_p1_y_q    <= p1_y;
                pend_p2_x_q    <= p2_x;
                pend_p2_y_q    <= p2_y;
                pending_full_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rgb_d = BG_RGB;
        if (!de1_q)       rgb_d = '0;
        else if (in1_q)   rgb_d = P1_RGB;
        else if (in2_q)   rgb_d = P2_RGB;
        else if (floor_q) rgb_d = FLOOR_RGB;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in1_q     <= 1'b0;
            in2_q     <= 1'b0;
            floor_q   <= 1'b0;
            de1_q     <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            rgb_q     <= '0;
            blank_n_q <= 1'b0;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b1;
        end else begin
            in1_q     <= w_in1;
            in2_q     <= w_in2;
            floor_q   <= ({1'b0, y_coord} >= c_floor);
            de1_q     <= display_en;
            hs1_q     <= hsync_in;
            vs1_q     <= vsync_in;
            rgb_q     <= rgb_d;
            blank_n_q <= de1_q;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
        end
    end

`ifdef FIGHTER_HITBOX_EN
    logic overlap_q;
    logic hit_q;

    // Overlap seen during a frame is published at the next boundary for one frame
    always_ff @(posedge clk) begin
        if (!reset) begin
            overlap_q <= 1'b0;
            hit_q     <= 1'b0;
        end else if (w_edge) begin
            hit_q     <= overlap_q;
            overlap_q <= 1'b0;
        end else if (in1_q && in2_q && de1_q) begin
            overlap_q <= 1'b1;
        end
    end

    assign hit = hit_q;
`endif

    assign pos_ready   = ~pending_full_q;
    assign frame_start = frame_start_q;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign vga_hs      = hs2_q;
    assign vga_vs      = vs2_q;
    assign vga_blank_n = blank_n_q;

endmodule
`default_nettype wire

// File: tb/tb_fighter_renderer.sv
`default_nettype none
// =============================================================================
// Module      : tb_fighter_renderer
// Description : Self-checking bench for fighter_renderer against a frame-level
//               model; hit is checked when FIGHTER_HITBOX_EN is defined.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_fighter_renderer;

    localparam int          SW  = 64;
    localparam int          SH  = 96;
    localparam int          FY  = 400;
    localparam logic [23:0] BG  = 24'h203060;
    localparam logic [23:0] FL  = 24'h404040;
    localparam logic [23:0] P1C = 24'hE02020;
    localparam logic [23:0] P2C = 24'h2040E0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [9:0] x_coord, y_coord;
    logic       display_en, hsync_in, vsync_in;
    logic [9:0] p1_x, p1_y, p2_x, p2_y;
    logic       pos_valid, pos_ready, frame_start;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n;
`ifdef FIGHTER_HITBOX_EN
    logic       hit;
`endif

    fighter_renderer dut (
        .clk(clk), .reset(reset), .x_coord(x_coord), .y_coord(y_coord),
        .display_en(display_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .pos_valid(pos_valid), .pos_ready(pos_ready), .frame_start(frame_start),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs),
        .vga_vs(vga_vs), .vga_blank_n(vga_blank_n)
`ifdef FIGHTER_HITBOX_EN
        ,.hit(hit)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: positions as plain integers, outputs as a two-deep delay line
    int          m_act[4];
    int          m_pend[4];
    bit          m_pfull, m_vsprev, m_fs, m_hit, m_flag, m_ovprev;
    logic [23:0] e_rgb[2];
    bit          e_bn[2], e_hs[2], e_vs[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit in_spr(input int x, input int y, input int px, input int py);
        return (x >= px) && (x < px + SW) && (y >= py) && (y < py + SH);
    endfunction

    task automatic model_step();
        int          x, y;
        bit          i1, i2, edge_s;
        logic [23:0] c;
        x = int'(x_coord);
        y = int'(y_coord);
        e_rgb[1] = e_rgb[0]; e_bn[1] = e_bn[0]; e_hs[1] = e_hs[0]; e_vs[1] = e_vs[0];
        if (!reset) begin
            m_act[0] = 64;  m_act[1] = FY - SH;
            m_act[2] = 512; m_act[3] = FY - SH;
            m_pfull = 0; m_vsprev = 1; m_fs = 0; m_hit = 0; m_flag = 0; m_ovprev = 0;
            for (int k = 0; k < 2; k++) begin
                e_rgb[k] = 24'h0; e_bn[k] = 0; e_hs[k] = 1; e_vs[k] = 1;
            end
        end else begin
            i1 = in_spr(x, y, m_act[0], m_act[1]);
            i2 = in_spr(x, y, m_act[2], m_act[3]);
            if (!display_en) c = 24'h0;
            else if (i1)     c = P1C;
            else if (i2)     c = P2C;
            else if (y >= FY) c = FL;
            else             c = BG;
            e_rgb[0] = c; e_bn[0] = display_en; e_hs[0] = hsync_in; e_vs[0] = vsync_in;
            edge_s   = m_vsprev && !vsync_in;
            m_vsprev = vsync_in;
            m_fs     = edge_s;
            if (edge_s) begin
                m_hit  = m_flag;
                m_flag = 0;
            end else if (m_ovprev) begin
                m_flag = 1;
            end
            m_ovprev = i1 && i2 && display_en;
            if (edge_s && m_pfull) begin
                m_act   = m_pend;
                m_pfull = 0;
            end else if (pos_valid && !m_pfull) begin
                m_pend[0] = int'(p1_x); m_pend[1] = int'(p1_y);
                m_pend[2] = int'(p2_x); m_pend[3] = int'(p2_y);
                m_pfull   = 1;
            end
        end
    endtask

    task automatic compare();
        chk("rgb", {8'h0, vga_r, vga_g, vga_b}, {8'h0, e_rgb[1]});
        chk("blank_n", vga_blank_n, e_bn[1]);
        chk("vga_hs", vga_hs, e_hs[1]);
        chk("vga_vs", vga_vs, e_vs[1]);
        chk("frame_start", frame_start, m_fs);
        chk("pos_ready", pos_ready, !m_pfull);
`ifdef FIGHTER_HITBOX_EN
        chk("hit", hit, m_hit);
`endif
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        x_coord = '0; y_coord = '0; display_en = 0; hsync_in = 1; vsync_in = 1; pos_valid = 0;
    endtask

    task automatic send(input int a, input int b, input int c, input int d);
        p1_x = 10'(a); p1_y = 10'(b); p2_x = 10'(c); p2_y = 10'(d);
        pos_valid = 1;
        cycle();
        pos_valid = 0;
        p1_x = 10'($urandom); p1_y = 10'($urandom); p2_x = 10'($urandom); p2_y = 10'($urandom);
        chk("accept_ready_low", pos_ready, 1'b0);
    endtask

    task automatic frame();
        vsync_in = 0;
        cycle();
        chk("fs_pulse", frame_start, 1'b1);
        cycle();
        chk("fs_single", frame_start, 1'b0);
        vsync_in = 1;
        cycle();
    endtask

    task automatic pix(input int x, input int y, input string nm, input logic [23:0] exp);
        x_coord = 10'(x); y_coord = 10'(y); display_en = 1;
        cycle();
        display_en = 0;
        cycle();
        chk(nm, {8'h0, vga_r, vga_g, vga_b}, {8'h0, exp});
    endtask

    initial begin
        reset = 0;
        idle();
        p1_x = '0; p1_y = '0; p2_x = '0; p2_y = '0;
        repeat (3) cycle();
        chk("rst_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        chk("rst_blank_n", vga_blank_n, 1'b0);
        chk("rst_hs", vga_hs, 1'b1);
        chk("rst_vs", vga_vs, 1'b1);
        chk("rst_ready", pos_ready, 1'b1);
        chk("rst_fs", frame_start, 1'b0);
        reset = 1;
        cycle();

        pix(64, 304, "home_p1", P1C);
        pix(512, 399, "home_p2", P2C);
        pix(0, 450, "floor", FL);
        pix(0, 399, "above_floor", BG);

        send(100, 200, 512, 304);
        frame();
        pix(100, 200, "p1_corner", P1C);
        pix(164, 200, "p1_right_edge", BG);

        send(50, 50, 512, 304);
        pix(50, 50, "no_tear_new", BG);
        pix(100, 200, "no_tear_old", P1C);
        frame();
        chk("ready_after_commit", pos_ready, 1'b1);
        pix(50, 50, "new_pos", P1C);

        send(300, 300, 300, 300);
        frame();
        pix(310, 310, "p1_priority", P1C);
        frame();
`ifdef FIGHTER_HITBOX_EN
        chk("hit_set", hit, 1'b1);
`endif
        send(0, 0, 600, 0);
        frame();
        frame();
`ifdef FIGHTER_HITBOX_EN
        chk("hit_clear", hit, 1'b0);
`endif

        send(100, 200, 1000, 0);
        frame();
        pix(639, 0, "offscreen_p2", BG);
        pix(5, 0, "no_wrap", BG);
        pix(1010, 10, "p2_far", P2C);
        x_coord = 10'd100; y_coord = 10'd200; display_en = 0; hsync_in = 0;
        cycle();
        hsync_in = 1;
        cycle();
        chk("blank_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        chk("blank_n_low", vga_blank_n, 1'b0);
        chk("hs_delay", vga_hs, 1'b0);
        cycle();
        chk("hs_restore", vga_hs, 1'b1);

        send(50, 50, 50, 50);
        reset = 0;
        repeat (2) cycle();
        reset = 1;
        cycle();
        frame();
        pix(64, 304, "rst_discard_home", P1C);
        pix(50, 50, "rst_discard_old", BG);
        chk("rst_discard_ready", pos_ready, 1'b1);

        for (int i = 0; i < 20000; i++) begin
            reset      = ($urandom_range(0, 999) != 0);
            x_coord    = 10'(m_act[$urandom_range(0, 1) * 2] + int'($urandom_range(0, 80)) - 8);
            y_coord    = 10'(m_act[1] + int'($urandom_range(0, 120)) - 12);
            if ($urandom_range(0, 3) == 0) begin
                x_coord = 10'($urandom_range(0, 1023));
                y_coord = 10'($urandom_range(0, 520));
            end
            display_en = ($urandom_range(0, 7) != 0);
            hsync_in   = ($urandom_range(0, 9) != 0);
            vsync_in   = ((i % 64) >= 3);
            pos_valid  = ($urandom_range(0, 5) == 0);
            p1_x = 10'($urandom); p1_y = 10'($urandom);
            p2_x = 10'($urandom); p2_y = 10'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                p1_x = 10'($urandom_range(0, 600));
                p1_y = 10'($urandom_range(0, 450));
                p2_x = p1_x + 10'($urandom_range(0, 40));
                p2_y = p1_y + 10'($urandom_range(0, 40));
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
